// File: rtl/reg_file.sv
// 32 x WIDTH register file with two combinational read ports, one write port, and register 0 hard-wired to zero.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       read_reg_1,
    input  logic [4:0]       read_reg_2,
    input  logic [4:0]       write_reg,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_en,
    output logic [WIDTH-1:0] read_data_1,
    output logic [WIDTH-1:0] read_data_2
);

    // Register 0 has no storage, so it can never hold anything but zero.
    logic [WIDTH-1:0] regs_reg [1:31];
    logic [WIDTH-1:0] rd_view  [0:31];
    logic [31:1]      write_onehot;

    assign rd_view[0] = '0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            assign write_onehot[gi] = write_en && (write_reg == 5'(gi));
            assign rd_view[gi]      = regs_reg[gi];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (write_onehot[gi]) begin
                    regs_reg[gi] <= write_data;
                end
            end
        end
    endgenerate

`ifdef REG_FILE_BYPASS_EN
    logic bypass_1;
    logic bypass_2;

    // Forward only a write that will actually commit on the coming edge.
    assign bypass_1 = write_en && rst_n && (write_reg != 5'd0) && (read_reg_1 == write_reg);
    assign bypass_2 = write_en && rst_n && (write_reg != 5'd0) && (read_reg_2 == write_reg);

    assign read_data_1 = bypass_1 ? write_data : rd_view[read_reg_1];
    assign read_data_2 = bypass_2 ? write_data : rd_view[read_reg_2];
`else
    assign read_data_1 = rd_view[read_reg_1];
    assign read_data_2 = rd_view[read_reg_2];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: reset, write/read, register 0, write disable, same-cycle read, reset priority.
// Expected values are hand-computed constants; the same-cycle read expectation follows REG_FILE_BYPASS_EN.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        write_en;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;

    int checks = 0;
    int errors = 0;

    reg_file #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .write_en    (write_en),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        write_reg  = addr;
        write_data = data;
        write_en   = 1'b1;
        tick();
        write_en   = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        read_reg_1 = '0;
        read_reg_2 = '0;
        write_reg  = 5'd4;
        write_data = 32'h0BAD_F00D;
        write_en   = 1'b0;
        #2;
        tick();
        rst_n = 1'b1;

        // Reset: all addresses zero on both ports
        for (int a = 0; a < 32; a++) begin
            read_reg_1 = 5'(a);
            read_reg_2 = 5'(31 - a);
            #1;
            check($sformatf("reset_p1_a%0d", a), read_data_1, 32'h0);
            check($sformatf("reset_p2_a%0d", 31 - a), read_data_2, 32'h0);
        end

        // Write then read
        do_write(5'd5, 32'hDEAD_BEEF);
        do_write(5'd31, 32'h1234_5678);
        read_reg_1 = 5'd5;
        read_reg_2 = 5'd31;
        #1;
        check("wr_rd_p1_r5", read_data_1, 32'hDEAD_BEEF);
        check("wr_rd_p2_r31", read_data_2, 32'h1234_5678);
        for (int a = 1; a < 31; a++) begin
            if (a != 5) begin
                read_reg_1 = 5'(a);
                read_reg_2 = 5'(a);
                #1;
                check($sformatf("others_p1_a%0d", a), read_data_1, 32'h0);
                check($sformatf("others_p2_a%0d", a), read_data_2, 32'h0);
            end
        end
        read_reg_1 = 5'd31;
        read_reg_2 = 5'd31;
        #1;
        check("same_addr_p1_r31", read_data_1, 32'h1234_5678);
        check("same_addr_p2_r31", read_data_2, 32'h1234_5678);

        // Register 0 ignores writes, including in the same cycle
        read_reg_1 = 5'd0;
        read_reg_2 = 5'd0;
        write_reg  = 5'd0;
        write_data = 32'hFFFF_FFFF;
        write_en   = 1'b1;
        #1;
        check("r0_same_cycle_p1", read_data_1, 32'h0);
        check("r0_same_cycle_p2", read_data_2, 32'h0);
        tick();
        write_en = 1'b0;
        check("r0_after_p1", read_data_1, 32'h0);
        check("r0_after_p2", read_data_2, 32'h0);
        read_reg_1 = 5'd5;
        #1;
        check("r0_no_side_effect_r5", read_data_1, 32'hDEAD_BEEF);

        // Write disabled
        do_write(5'd7, 32'h0000_0077);
        write_reg  = 5'd7;
        write_data = 32'hAAAA_AAAA;
        write_en   = 1'b0;
        tick();
        tick();
        tick();
        read_reg_1 = 5'd7;
        read_reg_2 = 5'd7;
        #1;
        check("wen0_p1_r7", read_data_1, 32'h0000_0077);
        check("wen0_p2_r7", read_data_2, 32'h0000_0077);

        // Same-cycle read of the written address
        do_write(5'd9, 32'h0000_0001);
        read_reg_1 = 5'd9;
        read_reg_2 = 5'd5;
        write_reg  = 5'd9;
        write_data = 32'h0000_0002;
        write_en   = 1'b1;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("same_cycle_p1_r9", read_data_1, 32'h0000_0002);
`else
        check("same_cycle_p1_r9", read_data_1, 32'h0000_0001);
`endif
        check("same_cycle_p2_r5", read_data_2, 32'hDEAD_BEEF);
        tick();
        write_en = 1'b0;
        check("after_edge_p1_r9", read_data_1, 32'h0000_0002);

        // Reset beats write
        rst_n      = 1'b0;
        write_reg  = 5'd3;
        write_data = 32'h0000_0055;
        write_en   = 1'b1;
        tick();
        rst_n    = 1'b1;
        write_en = 1'b0;
        read_reg_1 = 5'd3;
        read_reg_2 = 5'd5;
        #1;
        check("rst_wins_r3", read_data_1, 32'h0);
        check("rst_clears_r5", read_data_2, 32'h0);
        read_reg_2 = 5'd31;
        #1;
        check("rst_clears_r31", read_data_2, 32'h0);

        // Writes resume on the very next edge after reset deasserts
        do_write(5'd3, 32'h0000_0055);
        check("resume_p1_r3", read_data_1, 32'h0000_0055);
        read_reg_2 = 5'd3;
        #1;
        check("resume_p2_r3", read_data_2, 32'h0000_0055);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
- REQ-001: Parameter WIDTH, default 32, data width of each register and data port.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst_n  input  1  reset, synchronous, active-low, sampled on rising edge of clk.
- REQ-004: read_reg_1  input  5  address of read port 1.
- REQ-005: read_reg_2  input  5  address of read port 2.
- REQ-006: write_reg  input  5  destination address, decoded one-hot to 32 register write enables.
- REQ-007: write_data  input  WIDTH  data written to the addressed register.
- REQ-008: write_en  input  1  write strobe; 1 = write on next rising edge.
- REQ-009: read_data_1  output  WIDTH  contents selected by read_reg_1.
- REQ-010: read_data_2  output  WIDTH  contents selected by read_reg_2.

Function
- REQ-011: Storage SHALL be 32 registers, each WIDTH bits, indexed 0..31.
- REQ-012: The block SHALL decode write_reg so that at most one register is written per cycle.
- REQ-013: On a rising edge with rst_n=1 and write_en=1 and write_reg!=0, register[write_reg] SHALL take write_data.
- REQ-014: Write latency SHALL be one edge; the new value SHALL be visible on read ports from the cycle after that edge.
- REQ-015: Register 0 SHALL always read 0; writes to address 0 SHALL be ignored with no side effect.
- REQ-016: With write_en=0, no register SHALL change.
- REQ-017: Read ports SHALL be combinational; no clock latency from address change to data.
- REQ-018: Both read ports SHALL be independent; the same address on both SHALL return identical data.
- REQ-019: write_reg, write_data and read addresses SHALL have no effect on storage when write_en=0 or rst_n=0.
- REQ-020: No X SHALL appear on read_data_1 or read_data_2 after the first reset edge for any known-valued input.

Reset
- REQ-021: On a rising edge with rst_n=0, all 32 registers SHALL become 0.
- REQ-022: Reset SHALL dominate write_en in the same cycle; the write is discarded.
- REQ-023: Before the first reset edge, register contents are undefined.
- REQ-024: From the cycle after the reset edge, read_data_1 and read_data_2 SHALL be 0 for every address.
- REQ-025: Deasserting rst_n mid-sequence SHALL resume normal writes on the very next edge.

Configuration
- REQ-026: Macro REG_FILE_BYPASS_EN SHALL control write-to-read forwarding.
- REQ-027: With REG_FILE_BYPASS_EN defined:
  - When write_en=1, rst_n=1, write_reg!=0 and read_reg_N==write_reg, read_data_N SHALL equal write_data in the same cycle.
  - This applies to each port independently.
- REQ-028: Without REG_FILE_BYPASS_EN, read_data_N SHALL show the stored (pre-write) value until after the write edge.
- REQ-029: In both builds, address 0 SHALL read 0 even when write_reg=0 and write_en=1.

Verification
- REQ-030: Reset:
  - Stimulus: rst_n=0 for 1 edge.
  - Response: every address 0..31 reads 0 on both ports.
- REQ-031: Write then read:
  - Stimulus: write 0xDEADBEEF to reg 5, then 0x12345678 to reg 31.
  - Response: read_reg_1=5 returns 0xDEADBEEF and read_reg_2=31 returns 0x12345678; all other addresses stay 0.
- REQ-032: Register 0:
  - Stimulus: write 0xFFFFFFFF to reg 0.
  - Response: reads of address 0 return 0 on both ports.
- REQ-033: Write disabled:
  - Stimulus: write_en=0, write_reg=7, write_data=0xAAAAAAAA for 3 edges.
  - Response: reg 7 still reads its prior value.
- REQ-034: Same-cycle read of the written address:
  - Stimulus: reg 9 holds 0x1, then write 0x2 to reg 9 with read_reg_1=9.
  - Response with REG_FILE_BYPASS_EN: read_data_1=0x2 in that cycle.
  - Response without it: read_data_1=0x1 in that cycle and 0x2 after the edge.
- REQ-035: Reset beats write:
  - Stimulus: rst_n=0 and write_en=1 to reg 3 with 0x55 on the same edge.
  - Response: reg 3 reads 0 afterwards.
